serial_tx_8: RTL and testbench

- Parallel-in, serial-out transmitter.
- Accepts an 8-bit word loaded from the datapath (ld/d strobe style, as on the register blocks) and shifts it out on a single line.
- Frame: start bit, data LSB first, optional even parity bit, stop bit.
- Sits at the output side of the datapath; it is the sending end of the single-wire link whose receive side captures words into 8-bit registers.

---
 rtl/serial_tx_8.sv | 163 ++++++++++++++++
 tb/tb_serial_tx_8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_8.sv
// rtl/serial_tx_8.sv - parallel-in, serial-out frame transmitter
//
// Sends one DATA_W-bit word per frame on a single line that idles high:
// start bit (0), data LSB first, optional even-parity bit, stop bit (1).
// Each serial bit is held on tx for CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk    in   rising-edge system clock
//   rst    in   asynchronous active-high reset; abandons any frame in flight
//   ld     in   send request, sampled only while ready=1
//   d      in   word to send, captured on the accepting edge
//   ready  out  1 while idle and able to accept ld
//   tx     out  serial line
//   done   out  one-cycle pulse in the first idle cycle after a stop bit

module serial_tx_8 #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              parity_q,  parity_d;
    logic              tx_q,      tx_d;
    logic              ready_q,   ready_d;
    logic              done_q,    done_d;

    logic              bit_end;

    // Last cycle of the current bit period; the FSM advances on this edge.
    assign bit_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    state_d   = ST_START;
                    shreg_d   = d;
                    parity_d  = ^d;
                    div_d     = '0;
                    bit_cnt_d = '0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                div_d     = '0;
                bit_cnt_d = '0;
            end
        endcase

        // tx is registered from the *next* state so the line changes exactly
        // on bit boundaries and never carries a combinational glitch.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_8.sv
// tb/tb_serial_tx_8.sv - self-checking bench for serial_tx_8

module tb_serial_tx_8;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld0, ld1;
    logic [7:0] d0, d1;
    logic       ready0, tx0, done0;
    logic       ready1, tx1, done1;

    int total  = 0;
    int passed = 0;
    int sel    = 0;
    logic exp_q[$];

    serial_tx_8 #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .ld(ld0), .d(d0),
        .ready(ready0), .tx(tx0), .done(done0)
    );

    serial_tx_8 #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .ld(ld1), .d(d1),
        .ready(ready1), .tx(tx1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    endtask

    function automatic logic cur_tx();
        return (sel == 0) ? tx0 : tx1;
    endfunction

    function automatic logic cur_ready();
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic logic cur_done();
        return (sel == 0) ? done0 : done1;
    endfunction

    task automatic set_ld(input logic v, input logic [7:0] data);
        if (sel == 0) begin
            ld0 = v;
            d0  = data;
        end else begin
            ld1 = v;
            d1  = data;
        end
    endtask

    // Reference frame: start, data LSB first, even parity if enabled, stop.
    task automatic build(input logic [7:0] data);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (sel == 1) exp_q.push_back(logic'(ones % 2));
        exp_q.push_back(1'b1);
    endtask

    // Called at a negedge while idle; leaves us at the negedge of frame cycle 1.
    task automatic start_frame(input logic [7:0] data);
        chk("ready_before_ld", cur_ready(), 1);
        set_ld(1'b1, data);
        build(data);
        @(negedge clk);
    endtask

    // mode 0: ld low, d randomised; mode 1: ld=FF pulses at cycles 5 and 20;
    // mode 2: ld held high with the same word. Ends at the negedge of the done cycle.
    task automatic run_frame(input logic [7:0] data, input int mode);
        int n;
        n = exp_q.size() * CPB;
        for (int k = 1; k <= n; k++) begin
            chk("tx_bit", cur_tx(), exp_q[(k - 1) / CPB]);
            chk("ready_busy", cur_ready(), 0);
            chk("done_busy", cur_done(), 0);
            case (mode)
                1:       set_ld((k == 5) || (k == 20), 8'hFF);
                2:       set_ld(1'b1, data);
                default: set_ld(1'b0, 8'($urandom));
            endcase
            @(negedge clk);
        end
        chk("done_pulse", cur_done(), 1);
        chk("ready_after", cur_ready(), 1);
        chk("tx_after", cur_tx(), 1);
    endtask

    task automatic idle(input int n);
        set_ld(1'b0, 8'($urandom));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_tx", cur_tx(), 1);
            chk("idle_ready", cur_ready(), 1);
            chk("idle_done", cur_done(), 0);
        end
    endtask

    initial begin
        logic [7:0] data;
        rst = 1'b1;
        ld0 = 1'b0; ld1 = 1'b0;
        d0  = 8'h00; d1 = 8'h00;

        // Reset with ld low.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_tx", tx0, 1);
            chk("rst_ready", ready0, 1);
            chk("rst_done", done0, 0);
        end
        rst = 1'b0;
        sel = 0; idle(12);
        sel = 1; idle(2);

        // Default frame A5.
        sel = 0;
        start_frame(8'hA5);
        run_frame(8'hA5, 0);
        idle(3);

        // Parity frames: 01 -> parity 1, 03 -> parity 0.
        sel = 1;
        start_frame(8'h01);
        run_frame(8'h01, 0);
        idle(2);
        start_frame(8'h03);
        run_frame(8'h03, 0);
        idle(2);

        // ld pulses mid-frame are ignored.
        sel = 0;
        start_frame(8'h00);
        run_frame(8'h00, 1);
        idle(4);

        // Back-to-back: ld held through frame 1, accepted again in the done cycle.
        start_frame(8'h55);
        run_frame(8'h55, 2);
        start_frame(8'hAA);
        run_frame(8'hAA, 0);
        idle(2);

        // Reset mid-frame at cycle 17.
        start_frame(8'h00);
        for (int k = 1; k <= 16; k++) begin
            set_ld(1'b0, 8'($urandom));
            @(negedge clk);
        end
        chk("pre_rst_tx", tx0, 0);
        chk("pre_rst_ready", ready0, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx0, 1);
        chk("async_rst_ready", ready0, 1);
        chk("async_rst_done", done0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        data = 8'($urandom);
        start_frame(data);
        run_frame(data, 0);
        idle(1);

        // Randomised frames on both instances.
        for (int r = 0; r < 10; r++) begin
            sel  = int'($urandom_range(0, 1));
            data = 8'($urandom);
            start_frame(data);
            run_frame(data, 0);
            idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
